lut_cfg_loader: RTL and testbench
=================================

# lut_cfg_loader

Configuration sequencer for a bank of latch-based 4-input LUT cells. It accepts a 16-bit truth-table word and a target LUT index over a valid/ready handshake. It then serially writes the word into the selected LUT's 16 configuration latches, one bit at a time, using a glitch-safe setup/strobe/hold sequence. It sits between the configuration bus (host or shift-chain front end) and the LUT array, and is the only driver of the LUTs' address, data and config-enable inputs.

## Interface
- N_LUTS, 4, number of LUT cells driven (1..16)
- SEL_W, $clog2(N_LUTS) with minimum 1, width of the LUT select
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cfg_valid  in  1  request valid
- o_cfg_ready  out  1  loader idle, request accepted when valid&ready
- i_cfg_sel  in  SEL_W  target LUT index
- i_cfg_word  in  16  truth table; bit k is the LUT output for input k
- o_lut_addr  out  4  config address, shared by all LUTs
- o_lut_data  out  1  config data bit, shared by all LUTs
- o_lut_cfg_en  out  N_LUTS  one-hot config enable, per LUT
- o_busy  out  1  load in progress
- o_done  out  1  one-cycle pulse, load finished
- o_err  out  1  one-cycle pulse with o_done, select out of range

## Operation
- States: IDLE, SETUP, STROBE, HOLD, FINISH.
- IDLE: o_cfg_ready=1. On valid&ready, capture i_cfg_sel and i_cfg_word, clear the bit counter to 0, and go to SETUP.
- SETUP: o_lut_addr=bit count, o_lut_data=word[bit count], o_lut_cfg_en=0. Go to STROBE.
- STROBE: same addr and data; o_lut_cfg_en[sel]=1, all other enables 0. Go to HOLD.
- HOLD: same addr and data; o_lut_cfg_en=0. If bit count=15, go to FINISH. Otherwise increment the count and go to SETUP.
- FINISH: o_done=1 for this single cycle, o_busy=0. Go to IDLE.
- Address and data change only on the SETUP entry edge. The enable is never high in the same cycle that address or data change.
- Out-of-range select (sel ≥ N_LUTS): the full sequence still runs, but no enable bit ever asserts. o_err pulses together with o_done.
- o_cfg_ready=0 in every state except IDLE. Requests presented while busy are ignored and do not stall.
- o_busy=1 in SETUP, STROBE and HOLD.
- Bit counter is 4 bits and never wraps while in use; termination is on count=15.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE
  - o_lut_cfg_en=0, o_lut_addr=0, o_lut_data=0
  - o_busy=0, o_done=0, o_err=0
  - o_cfg_ready=1 from the first cycle after release
- Reset mid-load: enables drop immediately. The target LUT's contents are undefined and the host must reload it.
- Accept edge is cycle 0. Bit k occupies cycles 3k+1 (SETUP), 3k+2 (STROBE) and 3k+3 (HOLD).
- o_done is asserted in cycle 49. o_cfg_ready rises in cycle 50, so the next accept can occur no earlier than cycle 50.
- Throughput: one LUT per 50 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- LUT_CFG_SHADOW_EN
  - Defined: adds an N_LUTS×16 shadow register, written with the captured word on the FINISH cycle of each in-range load. Adds ports i_rd_sel (in, SEL_W) and o_rd_word (out, 16). o_rd_word is combinational from i_rd_sel; it is 0 after reset, and 0 for an out-of-range i_rd_sel.
  - Undefined: no shadow storage and no read-back ports. All other behaviour is identical.

## Structure
- Shared package lut_cfg_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, FINISH)
  - LUT_BITS=16 and LUT_ADDR_W=4
  - CYCLES_PER_BIT=3
- One sub-module, lut_cfg_onehot, decodes the registered select plus a strobe qualifier into o_lut_cfg_en. It outputs 0 for an out-of-range select.
- FSM, counter and capture registers live in the top module.

## Test plan
- Reset then load sel=0, word=16'hA5C3 -> 16 enable pulses on bit 0 only, each 1 cycle wide at cycles 2,5,…,47. Data sampled at each strobe matches the word bits LSB first. o_done in cycle 49.
- Back-to-back: valid held high with sel=1 word=16'hFFFF, then sel=2 word=16'h0001 -> second accept at cycle 50. LUT model readback: LUT1 returns 1 for all inputs; LUT2 returns 1 only for input 0.
- Valid pulsed during a load -> ignored; exactly one o_done; word and sel unchanged mid-load.
- sel=N_LUTS (out of range) -> o_lut_cfg_en stays 0 for the whole load; o_done and o_err pulse together in cycle 49.
- i_rst_n asserted at cycle 20 -> all enables 0 in the same cycle; after release o_cfg_ready=1 and a fresh load completes normally.
- LUT_CFG_SHADOW_EN defined: load sel=3 word=16'h1234 -> o_rd_word=16'h1234 for i_rd_sel=3 from cycle 50, and 0 for the other LUTs.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared types and constants for the LUT configuration loader.
// Holds the loader state encoding and the LUT geometry.
package lut_cfg_pkg;

  localparam int LUT_BITS       = 16;
  localparam int LUT_ADDR_W     = 4;
  localparam int CYCLES_PER_BIT = 3;

  localparam logic [LUT_ADDR_W-1:0] LAST_BIT =
    LUT_ADDR_W'(LUT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    FINISH
  } state_t;

  function automatic logic sel_in_range(
    input logic [31:0] sel,
    input int unsigned n
  );
    return sel < n;
  endfunction

endpackage

// File: rtl/lut_cfg_onehot.sv
// lut_cfg_onehot: select + strobe qualifier -> one-hot LUT config enable.
// Ports: sel (LUT index), stb (qualifier), en (N_LUTS enables, 0 if sel out of range).
module lut_cfg_onehot #(
  parameter int N_LUTS = 4,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic              stb,
  output logic [N_LUTS-1:0] en
);

  always_comb begin
    en = '0;
    for (int i = 0; i < N_LUTS; i++) begin
      en[i] = stb && (32'(sel) == 32'(i));
    end
  end

endmodule

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serial setup/strobe/hold writer for latch-based 4-input LUTs.
// Ports: cfg valid/ready/sel/word in; lut addr/data/cfg_en, busy, done, err out.
// Optional LUT_CFG_SHADOW_EN adds a shadow copy read via i_rd_sel/o_rd_word.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int N_LUTS = 4,
  parameter int SEL_W  = (N_LUTS > 1) ? $clog2(N_LUTS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [SEL_W-1:0]      i_cfg_sel,
  input  logic [LUT_BITS-1:0]   i_cfg_word,
  output logic [LUT_ADDR_W-1:0] o_lut_addr,
  output logic                  o_lut_data,
  output logic [N_LUTS-1:0]     o_lut_cfg_en,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef LUT_CFG_SHADOW_EN
  input  logic [SEL_W-1:0]      i_rd_sel,
  output logic [LUT_BITS-1:0]   o_rd_word,
`endif
  output logic                  o_err
);

  state_t                state_q;
  state_t                state_nxt;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      sel_nxt;
  logic [LUT_BITS-1:0]   word_q;
  logic [LUT_BITS-1:0]   word_nxt;
  logic [LUT_ADDR_W-1:0] cnt_q;
  logic [LUT_ADDR_W-1:0] cnt_nxt;
  logic [N_LUTS-1:0]     en_nxt;
  logic                  sel_ok;
  logic                  setup_entry;

  assign sel_ok = sel_in_range(32'(sel_q), N_LUTS);

  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    word_nxt  = word_q;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_cfg_valid) begin
          sel_nxt   = i_cfg_sel;
          word_nxt  = i_cfg_word;
          cnt_nxt   = '0;
          state_nxt = SETUP;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: state_nxt = HOLD;
      HOLD: begin
        if (cnt_q == LAST_BIT) begin
          state_nxt = FINISH;
        end else begin
          cnt_nxt   = cnt_q + 1'b1;
          state_nxt = SETUP;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Enable is decoded from the next state so it comes straight off a flop;
  // sel_q is already stable whenever STROBE is next.
  lut_cfg_onehot #(
    .N_LUTS (N_LUTS),
    .SEL_W  (SEL_W)
  ) u_onehot (
    .sel (sel_q),
    .stb (state_nxt == STROBE),
    .en  (en_nxt)
  );

  assign setup_entry = (state_nxt == SETUP) && (state_q != SETUP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      word_q  <= word_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Address/data move only on SETUP entry, a full cycle before the
  // enable rises and a full cycle after it falls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cfg_ready  <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_lut_cfg_en <= '0;
      o_lut_addr   <= '0;
      o_lut_data   <= 1'b0;
    end else begin
      o_cfg_ready  <= (state_nxt == IDLE);
      o_busy       <= (state_nxt == SETUP) ||
                      (state_nxt == STROBE) ||
                      (state_nxt == HOLD);
      o_done       <= (state_nxt == FINISH);
      o_err        <= (state_nxt == FINISH) && !sel_ok;
      o_lut_cfg_en <= en_nxt;
      if (setup_entry) begin
        o_lut_addr <= cnt_nxt;
        o_lut_data <= word_nxt[cnt_nxt];
      end
    end
  end

`ifdef LUT_CFG_SHADOW_EN
  logic [LUT_BITS-1:0] shadow_q [N_LUTS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_LUTS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (state_q == FINISH) begin
      for (int i = 0; i < N_LUTS; i++) begin
        if (32'(sel_q) == 32'(i)) begin
          shadow_q[i] <= word_q;
        end
      end
    end
  end

  always_comb begin
    o_rd_word = '0;
    for (int i = 0; i < N_LUTS; i++) begin
      if (32'(i_rd_sel) == 32'(i)) begin
        o_rd_word = shadow_q[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: directed + random loads checked against a LUT latch model.
// Built with N_LUTS=3 so that select value 3 is out of range.
module tb_lut_cfg_loader;

  localparam int N  = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [15:0]   word = '0;
  logic          ready;
  logic [3:0]    addr;
  logic          data;
  logic [N-1:0]  en;
  logic          busy;
  logic          done;
  logic          err;
`ifdef LUT_CFG_SHADOW_EN
  logic [SW-1:0] rd_sel = '0;
  logic [15:0]   rd_word;
`endif

  lut_cfg_loader #(
    .N_LUTS (N)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (valid),
    .o_cfg_ready  (ready),
    .i_cfg_sel    (sel),
    .i_cfg_word   (word),
    .o_lut_addr   (addr),
    .o_lut_data   (data),
    .o_lut_cfg_en (en),
    .o_busy       (busy),
    .o_done       (done),
`ifdef LUT_CFG_SHADOW_EN
    .i_rd_sel     (rd_sel),
    .o_rd_word    (rd_word),
`endif
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Event log plus a behavioural model of the latch array.
  int           stb_t [$];
  logic [3:0]   stb_a [$];
  logic         stb_d [$];
  logic [N-1:0] stb_e [$];
  int           done_t [$];
  int           err_t [$];
  int           glitches = 0;
  logic [15:0]  lut_mem [N];
  logic [3:0]   pa = '0;
  logic         pd = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (|en) begin
        stb_t.push_back(edge_cnt);
        stb_a.push_back(addr);
        stb_d.push_back(data);
        stb_e.push_back(en);
        if (addr != pa || data != pd) glitches++;
        if (!$onehot(en)) glitches++;
        for (int i = 0; i < N; i++) begin
          if (en[i]) lut_mem[i][addr] = data;
        end
      end
      if (done) done_t.push_back(edge_cnt);
      if (err) err_t.push_back(edge_cnt);
      pa = addr;
      pd = data;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int b_stb = 0;
  int b_done = 0;
  int b_err = 0;
  logic [15:0] sh_exp [4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bases();
    b_stb  = stb_t.size();
    b_done = done_t.size();
    b_err  = err_t.size();
  endtask

  task automatic start_load(input logic [SW-1:0] s, input logic [15:0] w,
                            input bit hold, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    sel = s;
    word = w;
    valid = 1'b1;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("accept_timeout", 32'd0, 32'd1);
    set_bases();
    @(posedge clk);
    #1;
    acc = edge_cnt;
    if (!hold) valid = 1'b0;
  endtask

  task automatic verify(input int acc, input int s, input logic [15:0] w,
                        input string tag);
    bit           inr;
    int           ns;
    int           nd;
    int           ne;
    int           bad;
    logic [N-1:0] oh;
    inr = (s < N);
    oh = '0;
    if (inr) oh[s] = 1'b1;
    ns = stb_t.size() - b_stb;
    nd = done_t.size() - b_done;
    ne = err_t.size() - b_err;
    chk({tag, ".strobes"}, ns, inr ? 16 : 0);
    bad = 0;
    for (int j = 0; j < ns; j++) begin
      if (stb_t[b_stb+j] != acc + 3*j + 1) bad++;
      if (stb_a[b_stb+j] != 4'(j)) bad++;
      if (stb_d[b_stb+j] !== w[j]) bad++;
      if (stb_e[b_stb+j] !== oh) bad++;
    end
    chk({tag, ".seq"}, bad, 0);
    chk({tag, ".done_cnt"}, nd, 1);
    chk({tag, ".done_cyc"}, (nd > 0) ? done_t[b_done] - acc + 1 : -1, 49);
    chk({tag, ".err_cnt"}, ne, inr ? 0 : 1);
    if (!inr) chk({tag, ".err_cyc"}, (ne > 0) ? err_t[b_err] - acc + 1 : -1, 49);
    if (inr) begin
      chk({tag, ".lut"}, lut_mem[s], w);
      sh_exp[s] = w;
    end
  endtask

  // Runs to cycle 50 of the load at acc, checking the done/ready edge.
  task automatic finish_load(input int acc, input int s, input logic [15:0] w,
                             input string tag);
    int n;
    n = 0;
    while (edge_cnt != acc + 48 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".done49"}, done, 1);
    chk({tag, ".rdy49"}, ready, 0);
    @(negedge clk);
    chk({tag, ".rdy50"}, ready, 1);
    chk({tag, ".busy50"}, busy, 0);
    verify(acc, s, w, tag);
  endtask

  task automatic shadow_check(input string tag);
`ifdef LUT_CFG_SHADOW_EN
    for (int i = 0; i < 4; i++) begin
      rd_sel = SW'(i);
      #1;
      chk(tag, rd_word, (i < N) ? sh_exp[i] : 16'h0);
    end
`else
    chk(tag, busy, 0);
`endif
  endtask

  initial begin
    int acc;
    int acc2;
    logic [15:0] w;
    int s;

    for (int i = 0; i < 4; i++) sh_exp[i] = '0;

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.en", en, 0);
    chk("rst.addr", addr, 0);
    chk("rst.data", data, 0);
    shadow_check("rst.shadow");

    start_load(0, 16'hA5C3, 0, acc);
    finish_load(acc, 0, 16'hA5C3, "basic");

    start_load(1, 16'hFFFF, 1, acc);
    sel = 2;
    word = 16'h0001;
    finish_load(acc, 1, 16'hFFFF, "b2b1");
    set_bases();
    @(posedge clk);
    #1;
    acc2 = edge_cnt;
    valid = 1'b0;
    chk("b2b.gap", acc2 - acc, 50);
    finish_load(acc2, 2, 16'h0001, "b2b2");
    chk("b2b.lut1", lut_mem[1], 16'hFFFF);

    w = 16'(($urandom));
    start_load(0, w, 0, acc);
    repeat (10) @(negedge clk);
    valid = 1'b1;
    sel = 1;
    word = ~w;
    @(negedge clk);
    valid = 1'b0;
    finish_load(acc, 0, w, "ignore");

    w = 16'(($urandom));
    start_load(3, w, 0, acc);
    finish_load(acc, 3, w, "oor");

    w = 16'(($urandom)) | 16'h0040;
    start_load(1, w, 0, acc);
    while (edge_cnt != acc + 19) @(negedge clk);
    chk("rstmid.pre_en", en, 3'b010);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.en", en, 0);
    chk("rstmid.busy", busy, 0);
    for (int i = 0; i < 4; i++) sh_exp[i] = '0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.ready", ready, 1);
    shadow_check("rstmid.shadow");
    w = 16'(($urandom));
    start_load(1, w, 0, acc);
    finish_load(acc, 1, w, "rstmid.reload");

    start_load(2, 16'h1234, 0, acc);
    finish_load(acc, 2, 16'h1234, "shadow_load");
    shadow_check("shadow.rd");

    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 2));
      w = 16'(($urandom));
      start_load(SW'(s), w, 0, acc);
      finish_load(acc, s, w, "rand");
    end
    shadow_check("final.shadow");
    chk("glitches", glitches, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
